// File: rtl/banco_reg_if.sv
// banco_reg_if: write-back port and the two decode read ports of banco_reg, bundled.
// The register bank itself uses the slave modport.
interface banco_reg_if #(
   parameter int ANCHO = 32
);
   logic             RegW;
   logic [4:0]       DW;
   logic [ANCHO-1:0] DatoW;
   logic [4:0]       AR1;
   logic [4:0]       AR2;
   logic [ANCHO-1:0] DR1;
   logic [ANCHO-1:0] DR2;

   modport master (
      output RegW, DW, DatoW, AR1, AR2,
      input  DR1, DR2
   );

   modport slave (
      input  RegW, DW, DatoW, AR1, AR2,
      output DR1, DR2
   );
endinterface

// File: rtl/banco_reg.sv
// banco_reg: NREG x ANCHO register bank, one clocked write port, two combinational read ports, reg 0 = 0.
// Define BANCO_REG_BYPASS_EN to forward same-cycle write data to a read port addressing DW.
module banco_reg #(
   parameter int ANCHO = 32,
   parameter int NREG  = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   banco_reg_if.slave bus
);

   logic [ANCHO-1:0] rf [NREG];
   logic             we;
   logic [ANCHO-1:0] dr1_next;
   logic [ANCHO-1:0] dr2_next;

   // Writes to register 0 or beyond the bank are silently dropped.
   assign we = bus.RegW && (bus.DW != 5'd0) && (int'(bus.DW) < NREG);

   for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
         assign rf[gi] = '0;
      end else begin : g_store
         logic [ANCHO-1:0] q_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               q_reg <= '0;
            end else if (we && (bus.DW == 5'(gi))) begin
               q_reg <= bus.DatoW;
            end
         end

         assign rf[gi] = q_reg;
      end
   end

`ifdef BANCO_REG_BYPASS_EN
   // Forwarding is suppressed during reset so the read ports stay at zero.
   logic byp_en;
   assign byp_en = rst_n && we;
`endif

   always_comb begin
      dr1_next = '0;
      for (int i = 1; i < NREG; i++) begin
         if (bus.AR1 == 5'(i)) begin
            dr1_next = rf[i];
         end
      end
`ifdef BANCO_REG_BYPASS_EN
      if (byp_en && (bus.AR1 == bus.DW)) begin
         dr1_next = bus.DatoW;
      end
`endif
   end

   always_comb begin
      dr2_next = '0;
      for (int i = 1; i < NREG; i++) begin
         if (bus.AR2 == 5'(i)) begin
            dr2_next = rf[i];
         end
      end
`ifdef BANCO_REG_BYPASS_EN
      if (byp_en && (bus.AR2 == bus.DW)) begin
         dr2_next = bus.DatoW;
      end
`endif
   end

   assign bus.DR1 = dr1_next;
   assign bus.DR2 = dr2_next;

endmodule
